// File: rtl/vx_commit_arbiter_if.sv
// ---------------------------------------------------------------------------
// vx_commit_arbiter_if
// Bundle of the commit arbiter's handshake signals: the per-unit commit
// streams on the input side and the single merged stream to the commit stage.
//
//   in_valid  [NUM_INPUTS]             per-unit beat valid
//   in_data   [NUM_INPUTS*DATA_WIDTH]  per-unit payload, unit i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_eop    [NUM_INPUTS]             last beat of a commit packet
//   in_ready  [NUM_INPUTS]             beat accepted when valid & ready
//   out_valid                          merged beat valid
//   out_data  [DATA_WIDTH]             merged payload
//   out_eop                            merged last-beat flag
//   out_sel   [SEL_W]                  source unit of the merged beat
//   out_ready                          commit stage accepts the merged beat
//
// Modports: master = execute units + commit stage (environment side),
//           slave  = the arbiter.
// ---------------------------------------------------------------------------
interface vx_commit_arbiter_if #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 64
);
    localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    logic [NUM_INPUTS-1:0]            in_valid;
    logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_INPUTS-1:0]            in_eop;
    logic [NUM_INPUTS-1:0]            in_ready;
    logic                             out_valid;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_eop;
    logic [SEL_W-1:0]                 out_sel;
    logic                             out_ready;

    modport master (
        output in_valid, in_data, in_eop, out_ready,
        input  in_ready, out_valid, out_data, out_eop, out_sel
    );

    modport slave (
        input  in_valid, in_data, in_eop, out_ready,
        output in_ready, out_valid, out_data, out_eop, out_sel
    );
endinterface

// File: rtl/vx_commit_arbiter.sv
// ---------------------------------------------------------------------------
// vx_commit_arbiter
// Merges NUM_INPUTS execute-unit commit streams into one stream. A
// round-robin arbiter picks a unit, a granted multi-beat packet holds the
// grant until its eop beat, and accepted beats go through a 2-entry skid
// FIFO so the merged output is registered yet sustains one beat per cycle.
//
// Ports:
//   clk           clock, all state on the rising edge
//   reset         asynchronous, active-low reset
//   bus           vx_commit_arbiter_if.slave (input streams + merged output)
//   perf_commits  [NUM_INPUTS*32] per-unit count of accepted eop beats
//                 (present only when VX_COMMIT_ARB_PERF_EN is defined)
//
// Optional feature macro: VX_COMMIT_ARB_PERF_EN
// ---------------------------------------------------------------------------
module vx_commit_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int DATA_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    vx_commit_arbiter_if.slave       bus
`ifdef VX_COMMIT_ARB_PERF_EN
    ,
    output logic [NUM_INPUTS*32-1:0] perf_commits
`endif
);
    localparam int SEL_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int ENTRY_W = DATA_WIDTH + 1 + SEL_W;

    typedef enum logic { ST_OPEN = 1'b0, ST_LOCKED = 1'b1 } state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]      lock_idx_q, lock_idx_d;
    logic [1:0]            count_q;
    logic                  rd_ptr_q;
    logic                  wr_ptr;
    logic [ENTRY_W-1:0]    mem_q [2];
    logic [ENTRY_W-1:0]    head;
    logic [SEL_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  grant_eop;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  can_push;
    logic                  push;
    logic                  pop;
    logic [NUM_INPUTS-1:0] ready;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_idx_d  = lock_idx_q;
        grant_idx   = '0;
        grant_valid = 1'b0;

        if (state_q == ST_LOCKED) begin
            // Only the packet owner may proceed; if it stalls, nobody does.
            grant_idx   = lock_idx_q;
            grant_valid = bus.in_valid[lock_idx_q];
        end else begin
            // Walk the search order backwards so the last hit written is the
            // one closest to rr_ptr.
            for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
                if (bus.in_valid[(int'(rr_ptr_q) + k) % NUM_INPUTS]) begin
                    grant_idx   = SEL_W'((int'(rr_ptr_q) + k) % NUM_INPUTS);
                    grant_valid = 1'b1;
                end
            end
        end

        grant_eop  = bus.in_eop[grant_idx];
        grant_data = bus.in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

        // A full FIFO still takes a beat when the head leaves this cycle.
        // Reset gates ready combinationally so it drops the instant reset asserts.
        can_push = reset && ((count_q != 2'd2) || bus.out_ready);
        push     = grant_valid && can_push;
        pop      = (count_q != 2'd0) && bus.out_ready;

        ready = '0;
        if (push) begin
            ready[grant_idx] = 1'b1;
            if (grant_eop) begin
                state_d  = ST_OPEN;
                rr_ptr_d = SEL_W'((int'(grant_idx) + 1) % NUM_INPUTS);
            end else begin
                state_d    = ST_LOCKED;
                lock_idx_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_OPEN;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Write slot is the entry just past the live ones; with two live entries
    // and a simultaneous pop that is the slot being vacated.
    assign wr_ptr = rd_ptr_q ^ count_q[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= '0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= {grant_data, grant_eop, grant_idx};
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = head[ENTRY_W-1 -: DATA_WIDTH];
    assign bus.out_eop   = head[SEL_W];
    assign bus.out_sel   = head[SEL_W-1:0];
    assign bus.in_ready  = ready;

`ifdef VX_COMMIT_ARB_PERF_EN
    logic [31:0] perf_q [NUM_INPUTS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                perf_q[i] <= '0;
            end
        end else if (push && grant_eop) begin
            perf_q[grant_idx] <= perf_q[grant_idx] + 32'd1;
        end
    end

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_perf
        assign perf_commits[gi*32 +: 32] = perf_q[gi];
    end
`endif
endmodule

// File: tb/tb_vx_commit_arbiter.sv
module tb_vx_commit_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          eop;
        logic [1:0]    sel;
    } beat_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    vx_commit_arbiter_if #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) bus ();

`ifdef VX_COMMIT_ARB_PERF_EN
    logic [N*32-1:0] perf_commits;
`endif

    vx_commit_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus)
`ifdef VX_COMMIT_ARB_PERF_EN
        ,
        .perf_commits (perf_commits)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: FIFO contents as a queue, arbitration state as ints.
    beat_t mq[$];
    int    m_rr;
    int    m_lock;
    int    m_perf [N];

    int n_checks;
    int n_fail;

    logic          obs_valid;
    logic [DW-1:0] obs_data;
    logic          obs_eop;
    logic [1:0]    obs_sel;
    logic [N-1:0]  obs_ready;
    logic          exp_valid;
    beat_t         exp_head;
    logic [N-1:0]  exp_ready;

    function automatic void model_reset();
        mq.delete();
        m_rr   = 0;
        m_lock = -1;
        for (int i = 0; i < N; i++) m_perf[i] = 0;
    endfunction

    // Which unit the rules say is accepted this cycle (-1 for none).
    function automatic int model_grant(input logic [N-1:0] v, input logic ordy);
        if (!(mq.size() < 2 || ordy)) return -1;
        if (m_lock >= 0) return v[m_lock] ? m_lock : -1;
        for (int k = 0; k < N; k++) begin
            if (v[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    // Drive one cycle from just after a falling edge: sample DUT and model
    // expectations before the rising edge, then advance the model.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] e,
                        input logic [N*DW-1:0] d, input logic ordy);
        int    g;
        beat_t b;
        bus.in_valid  = v;
        bus.in_eop    = e;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        obs_valid = bus.out_valid;
        obs_data  = bus.out_data;
        obs_eop   = bus.out_eop;
        obs_sel   = bus.out_sel;
        obs_ready = bus.in_ready;
        g         = model_grant(v, ordy);
        exp_valid = (mq.size() > 0);
        exp_head  = '0;
        if (exp_valid) exp_head = mq[0];
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        @(posedge clk);
        if (mq.size() > 0 && ordy) void'(mq.pop_front());
        if (g >= 0) begin
            b.data = d[g*DW +: DW];
            b.eop  = e[g];
            b.sel  = 2'(g);
            mq.push_back(b);
            if (e[g]) begin
                m_lock = -1;
                m_rr   = (g + 1) % N;
                m_perf[g]++;
            end else begin
                m_lock = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.in_valid  = '1;
        bus.in_eop    = '1;
        bus.in_data   = {N{64'hDEAD_BEEF_0123_4567}};
        bus.out_ready = 1'b1;
        reset = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
        if (bus.out_valid !== 1'b0) n_fail++;
        n_checks++; if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_in_ready got %b want 0000", bus.in_ready); end
        n_checks++; if (bus.out_sel !== 2'd0) begin n_fail++; $display("FAIL rst_out_sel got %0d want 0", bus.out_sel); end
        n_checks++; if (bus.out_eop !== 1'b0) begin n_fail++; $display("FAIL rst_out_eop got %b want 0", bus.out_eop); end
        n_checks++; if (bus.out_data !== 64'd0) begin n_fail++; $display("FAIL rst_out_data got %h want 0", bus.out_data); end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rst_hold got valid=%b ready=%b want 0/0000", bus.out_valid, bus.in_ready);
        end
        reset = 1'b1;
        bus.in_valid = '0;
        model_reset();
    endtask

    task automatic test_alternate();
        logic [N*DW-1:0] d;
        logic [1:0]      wsel;
        logic [DW-1:0]   wdata;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            d = '0;
            d[0*DW +: DW] = 64'h100 + 64'(k);
            d[2*DW +: DW] = 64'h200 + 64'(k);
            step(4'b0101, 4'b1111, d, 1'b1);
            n_checks++;
            if (obs_ready !== ((k % 2 == 0) ? 4'b0001 : 4'b0100)) begin
                n_fail++; $display("FAIL alt_ready k=%0d got %b", k, obs_ready);
            end
            if (k == 0) begin
                n_checks++;
                if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL alt_first_valid got %b want 0", obs_valid); end
            end else begin
                wsel  = ((k - 1) % 2 == 0) ? 2'd0 : 2'd2;
                wdata = ((wsel == 2'd0) ? 64'h100 : 64'h200) + 64'(k - 1);
                n_checks++;
                if (obs_valid !== 1'b1 || obs_sel !== wsel || obs_data !== wdata) begin
                    n_fail++;
                    $display("FAIL alt_out k=%0d got v=%b sel=%0d data=%h want v=1 sel=%0d data=%h",
                             k, obs_valid, obs_sel, obs_data, wsel, wdata);
                end
            end
        end
    endtask

    task automatic test_packet_lock();
        logic [3:0]  tv   [9] = '{4'h1, 4'h3, 4'h3, 4'h3, 4'h1, 4'h7, 4'h7, 4'h5, 4'h0};
        logic        te1  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0]  td1  [9] = '{8'h00, 8'h0A, 8'h0B, 8'h0C, 8'h00, 8'h0D, 8'h0E, 8'h00, 8'h00};
        logic [3:0]  trdy [9] = '{4'h1, 4'h2, 4'h2, 4'h2, 4'h1, 4'h2, 4'h2, 4'h4, 4'h0};
        logic [1:0]  tsel [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd2};
        logic [7:0]  tdat [9] = '{8'h00, 8'h50, 8'h0A, 8'h0B, 8'h0C, 8'h54, 8'h0D, 8'h0E, 8'h97};
        logic [N*DW-1:0] d;
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            d = '0;
            d[0*DW +: DW] = 64'h50 + 64'(k);
            d[1*DW +: DW] = 64'(td1[k]);
            d[2*DW +: DW] = 64'h90 + 64'(k);
            step(tv[k], {1'b0, 1'b1, te1[k], 1'b1}, d, 1'b1);
            n_checks++;
            if (obs_ready !== trdy[k]) begin
                n_fail++; $display("FAIL pkt_ready k=%0d got %b want %b", k, obs_ready, trdy[k]);
            end
            if (k > 0) begin
                n_checks++;
                if (obs_valid !== 1'b1 || obs_sel !== tsel[k] || obs_data !== 64'(tdat[k])) begin
                    n_fail++;
                    $display("FAIL pkt_out k=%0d got v=%b sel=%0d data=%h want sel=%0d data=%h",
                             k, obs_valid, obs_sel, obs_data, tsel[k], tdat[k]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int              accepted;
        int              received;
        logic [DW-1:0]   nxt;
        logic [DW-1:0]   want;
        logic [N*DW-1:0] d;
        apply_reset();
        nxt = 1;
        accepted = 0;
        for (int k = 0; k < 5; k++) begin
            d = '0;
            d[3*DW +: DW] = nxt;
            step(4'b1000, 4'b1000, d, 1'b0);
            if (obs_ready[3]) begin accepted++; nxt++; end
            if (k >= 2) begin
                n_checks++;
                if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready k=%0d got %b want 0000", k, obs_ready); end
            end
        end
        n_checks++;
        if (accepted != 2) begin n_fail++; $display("FAIL bp_accepted got %0d want 2", accepted); end
        want = 1;
        received = 0;
        for (int k = 0; k < 8; k++) begin
            d = '0;
            d[3*DW +: DW] = nxt;
            step((k < 4) ? 4'b1000 : 4'b0000, 4'b1000, d, 1'b1);
            if (k == 0) begin
                n_checks++;
                if (obs_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_full_accept got %b want 1000", obs_ready); end
            end
            if (obs_ready[3]) begin accepted++; nxt++; end
            if (obs_valid) begin
                n_checks++;
                if (obs_data !== want) begin n_fail++; $display("FAIL bp_order got %h want %h", obs_data, want); end
                want++;
                received++;
            end
        end
        n_checks++;
        if (received != accepted || accepted != 6) begin
            n_fail++; $display("FAIL bp_count got received=%0d accepted=%0d want 6/6", received, accepted);
        end
    endtask

    task automatic test_lock_stall();
        logic [N*DW-1:0] d;
        apply_reset();
        d = '0;
        d[0*DW +: DW] = 64'h20;
        d[1*DW +: DW] = 64'h31;
        step(4'b0010, 4'b0001, d, 1'b1);
        n_checks++;
        if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_first got %b want 0010", obs_ready); end
        for (int k = 0; k < 3; k++) begin
            step(4'b0001, 4'b0001, d, 1'b1);
            n_checks++;
            if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready k=%0d got %b want 0000", k, obs_ready); end
        end
        d[1*DW +: DW] = 64'h32;
        step(4'b0011, 4'b0011, d, 1'b1);
        n_checks++;
        if (obs_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_resume got %b want 0010", obs_ready); end
        step(4'b0001, 4'b0001, d, 1'b1);
        n_checks++;
        if (obs_ready !== 4'b0001 || obs_sel !== 2'd1 || obs_data !== 64'h32 || obs_eop !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_tail got ready=%b sel=%0d data=%h eop=%b want 0001/1/32/1", obs_ready, obs_sel, obs_data, obs_eop);
        end
    endtask

    task automatic test_reset_midpacket();
        logic [N*DW-1:0] d;
        apply_reset();
        d = '0;
        d[2*DW +: DW] = 64'h41;
        step(4'b0100, 4'b0000, d, 1'b0);
        d[2*DW +: DW] = 64'h42;
        step(4'b0100, 4'b0000, d, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_setup got valid=%b want 1", bus.out_valid); end
        for (int i = 0; i < N; i++) d[i*DW +: DW] = 64'h600 + 64'(i);
        bus.in_valid  = '1;
        bus.in_eop    = '1;
        bus.in_data   = d;
        bus.out_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0000 || bus.out_data !== 64'd0) begin
            n_fail++;
            $display("FAIL midrst_clear got valid=%b ready=%b data=%h want 0/0000/0", bus.out_valid, bus.in_ready, bus.out_data);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        step(4'b1111, 4'b1111, d, 1'b1);
        n_checks++;
        if (obs_ready !== 4'b0001 || obs_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_first got ready=%b valid=%b want 0001/0", obs_ready, obs_valid);
        end
        step(4'b1111, 4'b1111, d, 1'b1);
        n_checks++;
        if (obs_ready !== 4'b0010 || obs_sel !== 2'd0 || obs_data !== 64'h600) begin
            n_fail++; $display("FAIL midrst_next got ready=%b sel=%0d data=%h want 0010/0/600", obs_ready, obs_sel, obs_data);
        end
    endtask

    task automatic test_random();
        logic [N*DW-1:0] d;
        logic [N-1:0]    v;
        logic [N-1:0]    e;
        logic            ordy;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) d[i*DW +: DW] = {$urandom, $urandom};
            v    = 4'($urandom);
            e    = 4'($urandom) | 4'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            step(v, e, d, ordy);
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_fail++; $display("FAIL rnd_ready c=%0d got %b want %b", c, obs_ready, exp_ready);
            end
            n_checks++;
            if (obs_valid !== exp_valid) begin
                n_fail++; $display("FAIL rnd_valid c=%0d got %b want %b", c, obs_valid, exp_valid);
            end
            if (exp_valid) begin
                n_checks++;
                if (obs_data !== exp_head.data || obs_eop !== exp_head.eop || obs_sel !== exp_head.sel) begin
                    n_fail++;
                    $display("FAIL rnd_head c=%0d got %h/%b/%0d want %h/%b/%0d", c,
                             obs_data, obs_eop, obs_sel, exp_head.data, exp_head.eop, exp_head.sel);
                end
            end
        end
    endtask

`ifdef VX_COMMIT_ARB_PERF_EN
    task automatic test_perf();
        logic [N*DW-1:0] d;
        apply_reset();
        n_checks++;
        if (perf_commits !== '0) begin n_fail++; $display("FAIL perf_reset got %h want 0", perf_commits); end
        for (int k = 0; k < 10; k++) begin
            d = '0;
            d[2*DW +: DW] = 64'(k);
            step(4'b0100, 4'b0100, d, 1'b1);
        end
        step(4'b0000, 4'b0000, d, 1'b1);
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (perf_commits[i*32 +: 32] !== 32'(m_perf[i]) || m_perf[i] != ((i == 2) ? 10 : 0)) begin
                n_fail++; $display("FAIL perf_count i=%0d got %0d want %0d", i, perf_commits[i*32 +: 32], (i == 2) ? 10 : 0);
            end
        end
    endtask
`endif

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        bus.in_valid  = '0;
        bus.in_eop    = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_alternate();
        test_packet_lock();
        test_backpressure();
        test_lock_stall();
        test_reset_midpacket();
        test_random();
`ifdef VX_COMMIT_ARB_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
